// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line responder: receives a 48-bit host command,
// validates framing and CRC7, waits for card logic, then returns a
// 48-bit response after the Ncr gap.
//
// state        | meaning
// -------------+-----------------------------------------------------
// ST_IDLE      | line released, watching for a start bit
// ST_RECEIVE   | shifting in command bits 46..0
// ST_CHECK     | one cycle: validate frame, publish or reject
// ST_WAIT_RESP | waiting for card logic, counting the Ncr gap/timeout
// ST_SEND      | driving the 48-bit response, bit47 first
module sd_card_cmd_responder #(
    parameter int NCR_MIN      = 2,
    parameter int RESP_TIMEOUT = 64,
    parameter int CRC_GEN      = 1
) (
    input  logic        iClock_SD,
    input  logic        iReset,
    input  logic        iCmd_in,
    input  logic        iIdle_in,
    input  logic [47:0] iResponse,
    input  logic        iResponse_load,
    input  logic        iNo_response,
    output logic        oCmd_out,
    output logic        oCmd_oe,
    output logic [47:0] oCommand,
    output logic        oCommand_strobe,
    output logic        oCrc_error,
    output logic        oResp_timeout,
    output logic        oResp_done,
    output logic        oBusy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RECEIVE,
        ST_CHECK,
        ST_WAIT_RESP,
        ST_SEND
    } state_t;

    localparam logic [15:0] LP_NCR_MIN = 16'(NCR_MIN);
    localparam logic [15:0] LP_TIMEOUT = 16'(RESP_TIMEOUT);

    // CRC7, polynomial x^7 + x^3 + 1, zero initial value, MSB first.
    function automatic logic [6:0] f_crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    state_t      r_state,     w_state;
    logic [47:0] r_rx,        w_rx;
    logic [5:0]  r_bit_cnt,   w_bit_cnt;
    logic [15:0] r_wait_cnt,  w_wait_cnt;
    logic [47:0] r_tx,        w_tx;
    logic        r_tx_valid,  w_tx_valid;
    logic        r_cmd_out,   w_cmd_out;
    logic        r_cmd_oe,    w_cmd_oe;
    logic [47:0] r_command,   w_command;
    logic        r_strobe,    w_strobe;
    logic        r_crc_err,   w_crc_err;
    logic        r_timeout,   w_timeout;
    logic        r_done,      w_done;
    logic        r_busy,      w_busy;

    logic        w_frame_ok;
    logic [47:0] w_resp_word;

    // Frame checks and the response word as it will be latched.
    always_comb begin
        w_frame_ok  = r_rx[46] && r_rx[0] && (r_rx[7:1] == f_crc7(r_rx[47:8]));
        w_resp_word = (CRC_GEN != 0) ? {iResponse[47:8], f_crc7(iResponse[47:8]), 1'b1}
                                     : iResponse;
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state    = r_state;
        w_rx       = r_rx;
        w_bit_cnt  = r_bit_cnt;
        w_wait_cnt = r_wait_cnt;
        w_tx       = r_tx;
        w_tx_valid = r_tx_valid;
        w_cmd_out  = r_cmd_out;
        w_cmd_oe   = r_cmd_oe;
        w_command  = r_command;
        w_strobe   = 1'b0;
        w_crc_err  = 1'b0;
        w_timeout  = 1'b0;
        w_done     = 1'b0;

        if (iIdle_in) begin
            w_state    = ST_IDLE;
            w_cmd_oe   = 1'b0;
            w_cmd_out  = 1'b1;
            w_tx_valid = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cmd_oe   = 1'b0;
                    w_cmd_out  = 1'b1;
                    w_tx_valid = 1'b0;
                    if (!iCmd_in) begin
                        w_rx      = {r_rx[46:0], iCmd_in};
                        w_bit_cnt = 6'd46;
                        w_state   = ST_RECEIVE;
                    end
                end
                ST_RECEIVE: begin
                    w_rx = {r_rx[46:0], iCmd_in};
                    if (r_bit_cnt == 6'd0) begin
                        w_state = ST_CHECK;
                    end else begin
                        w_bit_cnt = r_bit_cnt - 6'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_frame_ok) begin
                        w_command  = r_rx;
                        w_strobe   = 1'b1;
                        w_wait_cnt = 16'd1;
                        w_tx_valid = 1'b0;
                        w_state    = ST_WAIT_RESP;
                    end else begin
                        w_crc_err = 1'b1;
                        w_state   = ST_IDLE;
                    end
                end
                ST_WAIT_RESP: begin
                    w_wait_cnt = r_wait_cnt + 16'd1;
                    if (iNo_response) begin
                        w_tx_valid = 1'b0;
                        w_state    = ST_IDLE;
                    end else if (r_tx_valid && (r_wait_cnt >= LP_NCR_MIN)) begin
                        // First response bit goes out on this edge.
                        w_cmd_oe  = 1'b1;
                        w_cmd_out = r_tx[47];
                        w_tx      = {r_tx[46:0], 1'b1};
                        w_bit_cnt = 6'd47;
                        w_state   = ST_SEND;
                    end else if (iResponse_load) begin
                        w_tx       = w_resp_word;
                        w_tx_valid = 1'b1;
                    end else if (!r_tx_valid && (r_wait_cnt == LP_TIMEOUT)) begin
                        w_timeout = 1'b1;
                        w_state   = ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (r_bit_cnt == 6'd0) begin
                        w_cmd_oe   = 1'b0;
                        w_cmd_out  = 1'b1;
                        w_done     = 1'b1;
                        w_tx_valid = 1'b0;
                        w_state    = ST_IDLE;
                    end else begin
                        w_cmd_out = r_tx[47];
                        w_tx      = {r_tx[46:0], 1'b1};
                        w_bit_cnt = r_bit_cnt - 6'd1;
                    end
                end
                default: begin
                    w_state   = ST_IDLE;
                    w_cmd_oe  = 1'b0;
                    w_cmd_out = 1'b1;
                end
            endcase
        end

        w_busy = (w_state != ST_IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge iClock_SD) begin
        if (iReset) begin
            r_state    <= ST_IDLE;
            r_rx       <= '0;
            r_bit_cnt  <= '0;
            r_wait_cnt <= '0;
            r_tx       <= '0;
            r_tx_valid <= 1'b0;
            r_cmd_out  <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_command  <= '0;
            r_strobe   <= 1'b0;
            r_crc_err  <= 1'b0;
            r_timeout  <= 1'b0;
            r_done     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rx       <= w_rx;
            r_bit_cnt  <= w_bit_cnt;
            r_wait_cnt <= w_wait_cnt;
            r_tx       <= w_tx;
            r_tx_valid <= w_tx_valid;
            r_cmd_out  <= w_cmd_out;
            r_cmd_oe   <= w_cmd_oe;
            r_command  <= w_command;
            r_strobe   <= w_strobe;
            r_crc_err  <= w_crc_err;
            r_timeout  <= w_timeout;
            r_done     <= w_done;
            r_busy     <= w_busy;
        end
    end

    assign oCmd_out        = r_cmd_out;
    assign oCmd_oe         = r_cmd_oe;
    assign oCommand        = r_command;
    assign oCommand_strobe = r_strobe;
    assign oCrc_error      = r_crc_err;
    assign oResp_timeout   = r_timeout;
    assign oResp_done      = r_done;
    assign oBusy           = r_busy;

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Directed bench for sd_card_cmd_responder: a vector table of command
// frames and response actions, plus hand sequences for abort, reset
// and strobe corner cases.
module tb_sd_card_cmd_responder;

    localparam int NCR = 2;

    logic        clk = 1'b0;
    logic        iReset = 1'b1;
    logic        iCmd_in = 1'b1;
    logic        iIdle_in = 1'b0;
    logic [47:0] iResponse = '0;
    logic        iResponse_load = 1'b0;
    logic        iNo_response = 1'b0;
    logic        oCmd_out, oCmd_oe, oCommand_strobe, oCrc_error;
    logic        oResp_timeout, oResp_done, oBusy;
    logic [47:0] oCommand;

    sd_card_cmd_responder #(.NCR_MIN(NCR), .RESP_TIMEOUT(64), .CRC_GEN(1)) dut (
        .iClock_SD(clk), .iReset(iReset), .iCmd_in(iCmd_in), .iIdle_in(iIdle_in),
        .iResponse(iResponse), .iResponse_load(iResponse_load), .iNo_response(iNo_response),
        .oCmd_out(oCmd_out), .oCmd_oe(oCmd_oe), .oCommand(oCommand),
        .oCommand_strobe(oCommand_strobe), .oCrc_error(oCrc_error),
        .oResp_timeout(oResp_timeout), .oResp_done(oResp_done), .oBusy(oBusy)
    );

    always #5 clk = ~clk;

    localparam int M_BAD = 0, M_NORESP = 1, M_LOAD = 2, M_TIMEOUT = 3;

    typedef struct {
        logic [47:0] frame;
        logic        valid;
        int          mode;
        logic [47:0] resp;
        logic [47:0] line;
    } vec_t;

    vec_t vecs[8];

    int n_tests = 0, n_fail = 0;
    int cyc = 0, check_cyc = 0, first_oe = -1, to_cyc = 0;
    int cnt_strobe = 0, cnt_crc = 0, cnt_to = 0, cnt_done = 0, cnt_oe = 0;
    int bad_idle_line = 0;
    logic [47:0] line = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (oCommand_strobe) cnt_strobe++;
        if (oCrc_error) cnt_crc++;
        if (oResp_timeout) begin cnt_to++; to_cyc = cyc; end
        if (oResp_done) cnt_done++;
        if (oCmd_oe) begin
            cnt_oe++;
            line = {line[46:0], oCmd_out};
            if (first_oe < 0) first_oe = cyc;
        end else if (oCmd_out !== 1'b1) begin
            bad_idle_line++;
        end
    endtask

    task automatic clr();
        cnt_strobe = 0; cnt_crc = 0; cnt_to = 0; cnt_done = 0; cnt_oe = 0;
        first_oe = -1; line = '0;
    endtask

    task automatic send_frame(input logic [47:0] f);
        for (int i = 47; i >= 0; i--) begin
            iCmd_in = f[i];
            tick();
        end
        iCmd_in = 1'b1;
    endtask

    // Shift a frame and take the CHECK edge; leaves the DUT in WAIT_RESP if valid.
    task automatic command(input logic [47:0] f);
        send_frame(f);
        tick();
        check_cyc = cyc;
    endtask

    task automatic do_load(input logic [47:0] w);
        iResponse = w;
        iResponse_load = 1'b1;
        tick();
        iResponse_load = 1'b0;
    endtask

    initial begin
        vecs[0] = '{48'h400000000095, 1'b1, M_NORESP,  48'h0, 48'h0};
        vecs[1] = '{48'h48000001AA87, 1'b1, M_LOAD,    48'h08000001AA00, 48'h08000001AA13};
        vecs[2] = '{48'h400000000097, 1'b0, M_BAD,     48'h0, 48'h0};
        vecs[3] = '{48'h400000000095, 1'b1, M_NORESP,  48'h0, 48'h0};
        vecs[4] = '{48'h48000001AA87, 1'b1, M_TIMEOUT, 48'h0, 48'h0};
        vecs[5] = '{48'h000000000001, 1'b0, M_BAD,     48'h0, 48'h0};
        vecs[6] = '{48'h400000000094, 1'b0, M_BAD,     48'h0, 48'h0};
        vecs[7] = '{48'h48000001AA87, 1'b1, M_LOAD,    48'h08000001AAFE, 48'h08000001AA13};

        tick(); tick();
        chk("reset_cmd_out", 64'(oCmd_out), 64'd1);
        chk("reset_cmd_oe", 64'(oCmd_oe), 64'd0);
        chk("reset_command", 64'(oCommand), 64'd0);
        chk("reset_busy", 64'(oBusy), 64'd0);
        iReset = 1'b0;
        tick(); tick();

        for (int v = 0; v < 8; v++) begin
            clr();
            command(vecs[v].frame);
            chk($sformatf("v%0d_strobe", v), 64'(cnt_strobe), 64'(vecs[v].valid));
            chk($sformatf("v%0d_crc_err", v), 64'(cnt_crc), 64'(!vecs[v].valid));
            if (vecs[v].valid)
                chk($sformatf("v%0d_command", v), 64'(oCommand), 64'(vecs[v].frame));
            case (vecs[v].mode)
                M_NORESP: begin
                    iNo_response = 1'b1;
                    tick();
                    iNo_response = 1'b0;
                    chk($sformatf("v%0d_noresp_busy", v), 64'(oBusy), 64'd0);
                    repeat (10) tick();
                    chk($sformatf("v%0d_noresp_oe", v), 64'(cnt_oe), 64'd0);
                end
                M_LOAD: begin
                    do_load(vecs[v].resp);
                    for (int k = 0; k < 200 && cnt_done == 0; k++) tick();
                    chk($sformatf("v%0d_done", v), 64'(cnt_done), 64'd1);
                    chk($sformatf("v%0d_line", v), 64'(line), 64'(vecs[v].line));
                    chk($sformatf("v%0d_oe_cycles", v), 64'(cnt_oe), 64'd48);
                    chk($sformatf("v%0d_ncr_gap", v), 64'((first_oe - check_cyc) >= NCR), 64'd1);
                    chk($sformatf("v%0d_done_oe", v), 64'(oCmd_oe), 64'd0);
                    chk($sformatf("v%0d_done_busy", v), 64'(oBusy), 64'd0);
                end
                M_TIMEOUT: begin
                    for (int k = 0; k < 100 && cnt_to == 0; k++) tick();
                    chk($sformatf("v%0d_timeout", v), 64'(cnt_to), 64'd1);
                    chk($sformatf("v%0d_timeout_cycle", v), 64'(to_cyc - check_cyc), 64'd64);
                    chk($sformatf("v%0d_timeout_busy", v), 64'(oBusy), 64'd0);
                    chk($sformatf("v%0d_timeout_oe", v), 64'(cnt_oe), 64'd0);
                end
                default: begin
                    chk($sformatf("v%0d_bad_busy", v), 64'(oBusy), 64'd0);
                    repeat (3) tick();
                    chk($sformatf("v%0d_bad_oe", v), 64'(cnt_oe), 64'd0);
                end
            endcase
            repeat (3) tick();
        end

        // Abort with iIdle_in after 20 response bits.
        clr();
        command(48'h48000001AA87);
        do_load(48'h08000001AA00);
        for (int k = 0; k < 100 && cnt_oe < 20; k++) tick();
        chk("abort_reached_send", 64'(cnt_oe), 64'd20);
        iIdle_in = 1'b1;
        tick();
        iIdle_in = 1'b0;
        chk("abort_oe", 64'(oCmd_oe), 64'd0);
        chk("abort_out", 64'(oCmd_out), 64'd1);
        chk("abort_busy", 64'(oBusy), 64'd0);
        repeat (60) tick();
        chk("abort_no_done", 64'(cnt_done), 64'd0);

        // Reset in the middle of a received command.
        clr();
        for (int i = 47; i >= 28; i--) begin
            iCmd_in = vecs[0].frame[i];
            tick();
        end
        iReset = 1'b1;
        iCmd_in = 1'b1;
        tick();
        chk("midrst_command", 64'(oCommand), 64'd0);
        chk("midrst_busy", 64'(oBusy), 64'd0);
        chk("midrst_oe", 64'(oCmd_oe), 64'd0);
        chk("midrst_out", 64'(oCmd_out), 64'd1);
        iReset = 1'b0;
        tick();
        clr();
        command(48'h400000000095);
        chk("postrst_strobe", 64'(cnt_strobe), 64'd1);
        chk("postrst_crc", 64'(cnt_crc), 64'd0);
        chk("postrst_command", 64'(oCommand), 64'h400000000095);
        iNo_response = 1'b1;
        tick();
        iNo_response = 1'b0;
        repeat (3) tick();

        // Load and no-response in the same cycle: no response, no timeout.
        clr();
        command(48'h48000001AA87);
        iResponse = 48'h08000001AA00;
        iResponse_load = 1'b1;
        iNo_response = 1'b1;
        tick();
        iResponse_load = 1'b0;
        iNo_response = 1'b0;
        repeat (80) tick();
        chk("both_oe", 64'(cnt_oe), 64'd0);
        chk("both_done", 64'(cnt_done), 64'd0);
        chk("both_timeout", 64'(cnt_to), 64'd0);
        chk("both_busy", 64'(oBusy), 64'd0);

        // A load while idle is dropped, so the next command times out.
        clr();
        do_load(48'h08000001AA00);
        tick();
        command(48'h400000000095);
        for (int k = 0; k < 100 && cnt_to == 0; k++) tick();
        chk("idle_load_timeout", 64'(cnt_to), 64'd1);
        chk("idle_load_oe", 64'(cnt_oe), 64'd0);

        chk("released_line_high", 64'(bad_idle_line), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
